// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame controller: FSM states and the
// saturation limit of the optional error counter.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/parity_acc.sv
// Serial even-parity accumulator: folds one bit per enabled clock into z,
// cleared synchronously by clr.
module parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic z
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z <= 1'b0;
    end else if (clr) begin
      z <= 1'b0;
    end else if (en) begin
      z <= z ^ x;
    end
  end

endmodule

// File: rtl/parity_frame_ctrl.sv
// Frame parity controller: accepts a WIDTH-bit word, serializes it LSB first
// through parity_acc and reports parity/mismatch. Define PARITY_ERR_CNT_EN to
// add the saturating err_cnt output.
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  output logic             ser_x,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_err
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             par_exp;
  logic             acc_z;
  logic             accept;
  logic             last_bit;
  logic             handshake;
  logic             shifting;

  assign shifting  = (state == SHIFT);
  assign accept    = in_valid && in_ready;
  assign last_bit  = shifting && (cnt == LAST);
  assign handshake = (state == DONE) && out_ready;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign ser_x     = shifting ? sr[0] : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift register and latched results are reset too, so an
  // aborted frame leaves nothing behind that could leak into a later result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      cnt     <= '0;
      par_exp <= 1'b0;
      out_par <= 1'b0;
      out_err <= 1'b0;
    end else if (accept) begin
      sr      <= in_data;
      cnt     <= '0;
      par_exp <= in_par;
    end else if (shifting) begin
      sr <= sr >> 1;
      if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end
      // The final bit is still on ser_x, so fold it in directly.
      if (last_bit) begin
        out_par <= acc_z ^ ser_x;
        out_err <= acc_z ^ ser_x ^ par_exp;
      end
    end
  end

  parity_acc u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (shifting),
    .x     (ser_x),
    .z     (acc_z)
  );

`ifdef PARITY_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= 8'd0;
    end else if (handshake && out_err && (err_cnt != ERR_CNT_MAX)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Scoreboard bench for parity_frame_ctrl: the driver queues hand-computed
// results, a negedge monitor checks every presented result against the queue.
module tb_parity_frame_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             ser_x;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic             out_par;
  logic             out_err;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  parity_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_par    (in_par),
    .ser_x     (ser_x),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_par   (out_par),
    .out_err   (out_err)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic par;
    logic err;
    int   vcyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   hs_cyc = -1;
  int   exp_cnt = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        if (!prev_valid) check("valid_latency", cyc, sb[0].vcyc);
        check("out_par", {31'd0, out_par}, {31'd0, sb[0].par});
        check("out_err", {31'd0, out_err}, {31'd0, sb[0].err});
        check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
`ifdef PARITY_ERR_CNT_EN
          check("err_cnt_at_handshake", {24'd0, err_cnt}, exp_cnt);
          if (sb[0].err && exp_cnt < 255) exp_cnt++;
`endif
          hs_cyc = cyc;
          void'(sb.pop_front());
        end
      end
    end
    prev_valid = out_valid;
  end

  // Called at a negedge; returns at the negedge of the first SHIFT cycle.
  task automatic send(input logic [7:0] d, input logic p, input logic ep,
                      input logic ee, input logic keep, output int acc_cyc);
    int waited = 0;
    in_data  = d;
    in_par   = p;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      acc_cyc  = -1;
      return;
    end
    acc_cyc = cyc;
    if (keep) sb.push_back('{par: ep, err: ee, vcyc: cyc + 1 + WIDTH});
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    in_par   = ~p;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int a;
    int a2;
    int w;
    logic [7:0] v;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_par    = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ser_x", {31'd0, ser_x}, 32'd0);
    check("rst_out_par", {31'd0, out_par}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the 4th SHIFT cycle discards the frame.
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, a);
    repeat (3) @(negedge clk);
    check("mid_busy_before_reset", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ser_x", {31'd0, ser_x}, 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    exp_cnt = 0;
    repeat (12) @(negedge clk);
    check("abort_idle_after", {31'd0, in_ready}, 32'd1);

    // A5 even parity, plus serial bit order LSB first.
    v = 8'hA5;
    send(v, 1'b0, 1'b0, 1'b0, 1'b1, a);
    for (int i = 0; i < WIDTH; i++) begin
      check("ser_x_bit", {31'd0, ser_x}, {31'd0, v[i]});
      @(negedge clk);
    end
    drain();

    send(8'h01, 1'b0, 1'b1, 1'b1, 1'b1, a);
    drain();
`ifdef PARITY_ERR_CNT_EN
    check("err_cnt_after_01", {24'd0, err_cnt}, 32'd1);
`endif

    send(8'h80, 1'b1, 1'b1, 1'b0, 1'b1, a);
    send(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, a);
    drain();

    // Back-pressure: result held for 5 cycles, input pulses ignored.
    out_ready = 1'b0;
    send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, a);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("hold_reached_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_data  = 8'h01;
      in_par   = 1'b0;
      @(negedge clk);
      check("hold_busy", {31'd0, busy}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Back-to-back: the second accept lands one edge after the handshake.
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, a);
    send(8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, a2);
    check("b2b_accept_gap", a2, hs_cyc + 1);
    drain();

`ifdef PARITY_ERR_CNT_EN
    for (int i = 0; i < 300; i++) begin
      send(8'h01, 1'b0, 1'b1, 1'b1, 1'b1, a);
    end
    drain();
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
    send(8'h07, 1'b0, 1'b1, 1'b1, 1'b1, a);
    drain();
    repeat (4) @(negedge clk);
    check("err_cnt_held", {24'd0, err_cnt}, 32'd255);
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
